// File: rtl/aud_pkg.sv
// Shared types and defaults for the audio playback path.
// Holds the FSM state encoding, speed-mode decode and bus width defaults.
package aud_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FETCH  = 2'd2,
        ST_PAUSED = 2'd3
    } aud_state_e;

    typedef enum logic [1:0] {
        MODE_NORMAL      = 2'd0,
        MODE_FAST        = 2'd1,
        MODE_SLOW_HOLD   = 2'd2,
        MODE_SLOW_INTERP = 2'd3
    } aud_mode_e;

    // The mode inputs are one-hot or all-low; fast wins if that is ever violated.
    function automatic aud_mode_e decode_mode(input logic fast,
                                              input logic slow_hold,
                                              input logic slow_interp);
        aud_mode_e m;
        m = MODE_NORMAL;
        if (fast)             m = MODE_FAST;
        else if (slow_hold)   m = MODE_SLOW_HOLD;
        else if (slow_interp) m = MODE_SLOW_INTERP;
        return m;
    endfunction

endpackage

// File: rtl/aud_play_ctrl_if.sv
// SRAM read port and DAC serializer handoff of the playback sequencer.
// master = sequencer side, slave = SRAM/serializer side.
interface aud_play_ctrl_if #(
    parameter int ADDR_W = aud_pkg::ADDR_W_DEF,
    parameter int DATA_W = aud_pkg::DATA_W_DEF
);
    logic [ADDR_W-1:0] o_sram_addr;
    logic              o_sram_rd;
    logic [DATA_W-1:0] i_sram_data;
    logic [DATA_W-1:0] o_dac_data;
    logic              o_dac_en;

    modport master (
        output o_sram_addr,
        output o_sram_rd,
        output o_dac_data,
        output o_dac_en,
        input  i_sram_data
    );

    modport slave (
        input  o_sram_addr,
        input  o_sram_rd,
        input  o_dac_data,
        input  o_dac_en,
        output i_sram_data
    );
endinterface

// File: rtl/aud_interp.sv
// Linear interpolation between two samples: s0 + trunc0((s1-s0)*k / F).
// Purely combinational so it can be shared with the record-monitor path.
module aud_interp
    import aud_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_s0,
    input  logic [DATA_W-1:0] i_s1,
    input  logic [2:0]        i_k,
    input  logic [3:0]        i_f,
    output logic [DATA_W-1:0] o_y
);
    localparam int PW = DATA_W + 4;

    logic signed [PW-1:0] diff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] fdiv;

    // Signed division truncates toward zero; |quotient| <= |s1-s0|, so no overflow.
    always_comb begin
        diff = $signed({{4{i_s1[DATA_W-1]}}, i_s1}) - $signed({{4{i_s0[DATA_W-1]}}, i_s0});
        prod = diff * $signed({{(PW-3){1'b0}}, i_k});
        fdiv = $signed({{(PW-4){1'b0}}, i_f});
        o_y  = i_s0 + DATA_W'(prod / fdiv);
    end

endmodule

// File: rtl/aud_play_ctrl.sv
// Playback sequencer: reads recorded samples from SRAM once per LRCK frame,
// applies the speed mode and hands one sample per frame to the DAC serializer.
//
// state  | meaning
// IDLE   | stopped, outputs cleared, waiting for play
// RUN    | playing, waiting for the LRCK rising-edge tick
// FETCH  | 4-cycle read/compute of the next sample (ph 0..3)
// PAUSED | outputs cleared, address and step held
module aud_play_ctrl
    import aud_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_play,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow_hold,
    input  logic              i_slow_interp,
    input  logic [2:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    aud_play_ctrl_if.master   bus,
    output logic [1:0]        o_state,
    output logic              o_done
);

    aud_state_e        state_q, state_d;
    aud_mode_e         mode_q, mode_d;
    logic [1:0]        ph_q, ph_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        spd_q, spd_d;
    logic [DATA_W-1:0] s0_q, s0_d;
    logic [DATA_W-1:0] s1_q, s1_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic              sram_rd_q, sram_rd_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              dac_en_q, dac_en_d;
    logic              done_q, done_d;
    logic              end_q, end_d;
    logic              hold_q, hold_d;
    logic              lrck_q, lrck_d;

    aud_mode_e         mode_in;
    logic              tick;
    logic              cmd_pause;
    logic              cfg_chg;
    logic              at_end;
    logic              past_end;
    logic [3:0]        f_val;
    logic [ADDR_W:0]   next_a;
    logic [2:0]        next_k;
    logic [DATA_W-1:0] interp_y;

    assign mode_in   = decode_mode(i_fast, i_slow_hold, i_slow_interp);
    assign tick      = i_daclrck & ~lrck_q;
    assign cmd_pause = i_pause & ~i_stop;
    assign cfg_chg   = (mode_in != mode_q) || (i_speed != spd_q);
    assign at_end    = (addr_q == i_end_addr);
    assign f_val     = {1'b0, spd_q} + 4'd1;

    aud_interp #(.DATA_W(DATA_W)) u_interp (
        .i_s0 (s0_q),
        .i_s1 (s1_q),
        .i_k  (k_q),
        .i_f  (f_val),
        .o_y  (interp_y)
    );

    // Next address is one bit wider so running past the end never wraps to 0.
    always_comb begin
        next_k = 3'd0;
        next_a = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
        case (mode_q)
            MODE_FAST: next_a = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, f_val};
            MODE_SLOW_HOLD, MODE_SLOW_INTERP: begin
                if (k_q != spd_q) begin
                    next_a = {1'b0, addr_q};
                    next_k = k_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    assign past_end = (next_a > {1'b0, i_end_addr});

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ph_d        = ph_q;
        addr_d      = addr_q;
        k_d         = k_q;
        spd_d       = spd_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        sram_addr_d = sram_addr_q;
        sram_rd_d   = 1'b0;
        dac_data_d  = dac_data_q;
        dac_en_d    = dac_en_q;
        done_d      = 1'b0;
        end_d       = end_q;
        hold_d      = hold_q;
        lrck_d      = i_daclrck;

        case (state_q)
            ST_IDLE: begin
                if (i_play && !i_pause) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                    k_d     = 3'd0;
                    end_d   = 1'b0;
                    mode_d  = mode_in;
                    spd_d   = i_speed;
                end
            end
            ST_RUN: begin
                if (cmd_pause) begin
                    state_d    = ST_PAUSED;
                    dac_en_d   = 1'b0;
                    dac_data_d = '0;
                end else if (tick && end_q) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    dac_en_d   = 1'b0;
                    dac_data_d = '0;
                    end_d      = 1'b0;
                    addr_d     = '0;
                    k_d        = 3'd0;
                end else if (tick) begin
                    state_d     = ST_FETCH;
                    ph_d        = 2'd0;
                    sram_addr_d = addr_q;
                    sram_rd_d   = 1'b1;
                    if (cfg_chg) begin
                        k_d    = 3'd0;
                        mode_d = mode_in;
                        spd_d  = i_speed;
                    end
                end
            end
            ST_FETCH: begin
                if (cmd_pause) begin
                    hold_d     = 1'b1;
                    dac_en_d   = 1'b0;
                    dac_data_d = '0;
                end
                case (ph_q)
                    2'd0: begin
                        ph_d = 2'd1;
                        if (mode_q == MODE_SLOW_INTERP) begin
                            sram_addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            sram_rd_d   = 1'b1;
                        end
                    end
                    2'd1: begin
                        ph_d = 2'd2;
                        s0_d = bus.i_sram_data;
                    end
                    2'd2: begin
                        ph_d = 2'd3;
                        s1_d = (mode_q == MODE_SLOW_INTERP && !at_end) ? bus.i_sram_data : s0_q;
                    end
                    default: begin
                        ph_d = 2'd0;
                        // A pause during the fetch keeps a/k so resume replays this sample.
                        if (hold_q || cmd_pause) begin
                            state_d    = ST_PAUSED;
                            hold_d     = 1'b0;
                            dac_en_d   = 1'b0;
                            dac_data_d = '0;
                        end else begin
                            state_d    = ST_RUN;
                            dac_data_d = (mode_q == MODE_SLOW_INTERP) ? interp_y : s0_q;
                            dac_en_d   = 1'b1;
                            addr_d     = next_a[ADDR_W-1:0];
                            k_d        = next_k;
                            end_d      = past_end;
                        end
                    end
                endcase
            end
            ST_PAUSED: begin
                if (i_play && !i_pause) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_stop) begin
            state_d     = ST_IDLE;
            ph_d        = 2'd0;
            addr_d      = '0;
            k_d         = 3'd0;
            sram_addr_d = '0;
            sram_rd_d   = 1'b0;
            dac_data_d  = '0;
            dac_en_d    = 1'b0;
            done_d      = 1'b0;
            end_d       = 1'b0;
            hold_d      = 1'b0;
        end
    end

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_NORMAL;
            ph_q        <= 2'd0;
            addr_q      <= '0;
            k_q         <= 3'd0;
            spd_q       <= 3'd0;
            s0_q        <= '0;
            s1_q        <= '0;
            sram_addr_q <= '0;
            sram_rd_q   <= 1'b0;
            dac_data_q  <= '0;
            dac_en_q    <= 1'b0;
            done_q      <= 1'b0;
            end_q       <= 1'b0;
            hold_q      <= 1'b0;
            lrck_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ph_q        <= ph_d;
            addr_q      <= addr_d;
            k_q         <= k_d;
            spd_q       <= spd_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            sram_addr_q <= sram_addr_d;
            sram_rd_q   <= sram_rd_d;
            dac_data_q  <= dac_data_d;
            dac_en_q    <= dac_en_d;
            done_q      <= done_d;
            end_q       <= end_d;
            hold_q      <= hold_d;
            lrck_q      <= lrck_d;
        end
    end

    assign bus.o_sram_addr = sram_addr_q;
    assign bus.o_sram_rd   = sram_rd_q;
    assign bus.o_dac_data  = dac_data_q;
    assign bus.o_dac_en    = dac_en_q;
    assign o_state         = state_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_aud_play_ctrl.sv
// Bench for aud_play_ctrl: SRAM model, LRCK generator and a sample scoreboard
// that is filled per playback case and drained at each left-half start.
`timescale 1ns/1ps
module tb_aud_play_ctrl;
    import aud_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          daclrck = 1'b0;
    logic          play = 1'b0, pause = 1'b0, stop = 1'b0;
    logic          fast = 1'b0, slow_hold = 1'b0, slow_interp = 1'b0;
    logic [2:0]    speed = 3'd0;
    logic [AW-1:0] end_addr = '0;
    logic [1:0]    state;
    logic          done;

    aud_play_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    aud_play_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_bclk        (clk),
        .i_rst_n       (rst_n),
        .i_daclrck     (daclrck),
        .i_play        (play),
        .i_pause       (pause),
        .i_stop        (stop),
        .i_fast        (fast),
        .i_slow_hold   (slow_hold),
        .i_slow_interp (slow_interp),
        .i_speed       (speed),
        .i_end_addr    (end_addr),
        .bus           (bus),
        .o_state       (state),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:63];
    logic [15:0] exp_q [$];
    logic [15:0] e;
    logic [15:0] early_data;
    logic        early_en;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int frame_cnt = 0;
    int done_cnt = 0;
    int pop_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (bus.o_sram_rd) bus.i_sram_data <= mem[bus.o_sram_addr[5:0]];
    end

    // 64 BCLK per frame: low (left) half cyc 0..31, high half 32..63.
    always @(negedge clk) begin
        cyc = (cyc == 63) ? 0 : cyc + 1;
        daclrck = (cyc >= 32);
        if (done) done_cnt++;
        if (bus.o_sram_rd) chk("rd_in_fetch", 32'(state), 32'(ST_FETCH));
        if (cyc == 37) begin
            early_data = bus.o_dac_data;
            early_en   = bus.o_dac_en;
        end
        if (cyc == 0) begin
            frame_cnt++;
            if (bus.o_dac_en) begin
                if (exp_q.size() == 0) chk("unexpected_en", 32'(bus.o_dac_en), 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sample", 32'(bus.o_dac_data), 32'(e));
                    chk("sample_latency", 32'(early_data), 32'(e));
                    chk("en_latency", 32'(early_en), 1);
                    pop_cnt++;
                end
            end
        end
    end

    task automatic cmd(input logic pl, input logic pa, input logic st);
        @(negedge clk);
        play = pl; pause = pa; stop = st;
        @(negedge clk);
        play = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic set_mode(input int m, input int spd);
        fast        = (m == 1);
        slow_hold   = (m == 2);
        slow_interp = (m == 3);
        speed       = 3'(spd);
    endtask

    task automatic expect_n(input int v, input int n);
        repeat (n) exp_q.push_back(16'(v));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 37 + 11);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(ST_IDLE));
        chk({tag, "_en"}, 32'(bus.o_dac_en), 0);
        chk({tag, "_data"}, 32'(bus.o_dac_data), 0);
    endtask

    task automatic wait_done(input int frames);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < frames * 64) begin
            @(negedge clk);
            n++;
        end
        repeat (80) @(negedge clk);
        chk("done_pulses", done_cnt - base, 1);
        check_cleared("end");
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_pops(input int n);
        int base = pop_cnt;
        int t = 0;
        while (pop_cnt - base < n && t < (n + 3) * 64) begin
            @(negedge clk);
            t++;
        end
        chk("pops_reached", pop_cnt - base, n);
    endtask

    task automatic wait_frames(input int n);
        int base = frame_cnt;
        int t = 0;
        while (frame_cnt - base < n && t < (n + 1) * 64) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic load_ramp(input int start, input int step, input int count);
        for (int i = 0; i < count; i++) mem[i] = 16'(start + i * step);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_mem();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sram_addr", 32'(bus.o_sram_addr), 0);
        chk("rst_sram_rd", 32'(bus.o_sram_rd), 0);
        chk("rst_done", 32'(done), 0);
        check_cleared("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Normal playback
        clear_mem(); load_ramp(100, 100, 4); end_addr = 20'd3; set_mode(0, 0);
        expect_n(100, 1); expect_n(200, 1); expect_n(300, 1); expect_n(400, 1);
        cmd(1, 0, 0); wait_done(10);

        // Fast, F=2
        clear_mem(); load_ramp(0, 10, 10); end_addr = 20'd9; set_mode(1, 1);
        for (int i = 0; i < 5; i++) expect_n(i * 20, 1);
        cmd(1, 0, 0); wait_done(10);

        // Slow hold, F=4
        clear_mem(); mem[0] = 16'd1000; mem[1] = 16'd2000; mem[2] = 16'd3000;
        end_addr = 20'd1; set_mode(2, 3);
        expect_n(1000, 4); expect_n(2000, 4);
        cmd(1, 0, 0); wait_done(14);

        // Slow interp, F=4, falling ramp; end sample holds instead of reading a+1
        clear_mem(); mem[0] = 16'd0; mem[1] = 16'(-100); mem[2] = 16'd9999;
        end_addr = 20'd1; set_mode(3, 3);
        expect_n(0, 1); expect_n(-25, 1); expect_n(-50, 1); expect_n(-75, 1); expect_n(-100, 4);
        cmd(1, 0, 0); wait_done(14);

        // Slow interp truncation toward zero, positive and negative
        clear_mem(); mem[0] = 16'd0; mem[1] = 16'd7; mem[2] = 16'd9999;
        expect_n(0, 1); expect_n(1, 1); expect_n(3, 1); expect_n(5, 1); expect_n(7, 4);
        cmd(1, 0, 0); wait_done(14);

        clear_mem(); mem[0] = 16'd0; mem[1] = 16'(-7); mem[2] = 16'd9999;
        expect_n(0, 1); expect_n(-1, 1); expect_n(-3, 1); expect_n(-5, 1); expect_n(-7, 4);
        cmd(1, 0, 0); wait_done(14);

        // Slow interp, F=3, nonzero base sample
        clear_mem(); mem[0] = 16'd300; mem[1] = 16'd0; mem[2] = 16'd9999;
        set_mode(3, 2);
        expect_n(300, 1); expect_n(200, 1); expect_n(100, 1); expect_n(0, 3);
        cmd(1, 0, 0); wait_done(12);

        // end_addr = 0 plays exactly one sample
        clear_mem(); mem[0] = 16'd555; end_addr = 20'd0; set_mode(0, 0);
        expect_n(555, 1);
        cmd(1, 0, 0); wait_done(6);

        // Pause after 2 frames, hold 3 frames, resume without skipping
        clear_mem(); load_ramp(10, 10, 5); end_addr = 20'd4; set_mode(0, 0);
        for (int i = 1; i <= 5; i++) expect_n(i * 10, 1);
        cmd(1, 0, 0); wait_pops(2);
        cmd(0, 1, 0);
        chk("pause_state", 32'(state), 32'(ST_PAUSED));
        chk("pause_en", 32'(bus.o_dac_en), 0);
        chk("pause_data", 32'(bus.o_dac_data), 0);
        for (int i = 0; i < 3; i++) begin
            wait_frames(1);
            chk("paused_en", 32'(bus.o_dac_en), 0);
            chk("paused_data", 32'(bus.o_dac_data), 0);
            chk("paused_state", 32'(state), 32'(ST_PAUSED));
        end
        cmd(1, 0, 0); wait_done(10);

        // Simultaneous pause + stop goes to IDLE
        expect_n(10, 1);
        cmd(1, 0, 0); wait_pops(1);
        cmd(0, 1, 1);
        check_cleared("pstop");
        wait_frames(2);
        chk("pstop_state_later", 32'(state), 32'(ST_IDLE));
        chk("pstop_queue", exp_q.size(), 0);
        exp_q.delete();

        // Async reset during FETCH T1, then replay from address 0
        clear_mem(); load_ramp(100, 100, 4); end_addr = 20'd3; set_mode(0, 0);
        expect_n(100, 1);
        cmd(1, 0, 0); wait_pops(1);
        n = 0;
        while (!bus.o_sram_rd && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_seen", 32'(bus.o_sram_rd), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        chk("midrst_rd", 32'(bus.o_sram_rd), 0);
        chk("midrst_addr", 32'(bus.o_sram_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        expect_n(100, 1); expect_n(200, 1); expect_n(300, 1); expect_n(400, 1);
        cmd(1, 0, 0); wait_done(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aud_play_ctrl.md
# aud_play_ctrl

Playback sequencer for the WM8731 DAC path. It reads 16-bit recorded samples from SRAM and applies the selected speed mode: normal, fast (sample skipping), slow with hold, or slow with linear interpolation. It delivers one sample per LRCK frame, together with the enable, to the DAC serializer. It sits between the top-level control FSM/SRAM port and the serializer, and runs entirely in the BCLK domain.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width (two's complement)

- i_bclk  in  1  codec bit clock; the only clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_daclrck  in  1  codec DAC LR clock. Low = left half, which the serializer transmits.
- i_play / i_pause / i_stop  in  1 each  single-cycle command pulses
- i_fast / i_slow_hold / i_slow_interp  in  1 each  speed mode. At most one is high; none high = normal.
- i_speed  in  3  factor F = i_speed+1 (1..8)
- i_end_addr  in  ADDR_W  last valid sample address
- o_sram_addr  out  ADDR_W  read address
- o_sram_rd  out  1  read strobe; data valid on i_sram_data the next cycle
- i_sram_data  in  DATA_W  SRAM read data
- o_dac_data  out  DATA_W  sample to the serializer
- o_dac_en  out  1  serializer enable
- o_state  out  2  current FSM state
- o_done  out  1  one-cycle pulse at end of recording

## Operation
- States: IDLE=0, RUN=1, FETCH=2, PAUSED=3.
- Tick: rising edge of i_daclrck, detected from a registered copy. The sample for the following low half is produced after the tick.
- Command priority in any state: stop > pause > play.
  - stop: go to IDLE, address := 0, k := 0, outputs cleared.
  - pause: RUN/FETCH go to PAUSED. An in-progress FETCH completes its writes but does not enable output.
- Play commands:
  - play in IDLE: address := 0, k := 0, go to RUN.
  - play in PAUSED: go to RUN, resume at the held address and k.
  - play in RUN: ignored.
- RUN, on a tick: go to FETCH.
- FETCH: issue reads, compute and register o_dac_data, set o_dac_en = 1, return to RUN.
- Address and step rules:
  - Normal: output s[a]; next a := a+1.
  - Fast: output s[a]; next a := a+F.
  - Slow hold: output s[a] for F consecutive frames. Step k runs 0..F-1; at k = F-1, k := 0 and a := a+1.
  - Slow interp: output s[a] + trunc0((s[a+1]-s[a])*k / F). k and a advance as in slow hold.
- Interp arithmetic:
  - Difference is 17-bit signed.
  - Product is 20-bit signed.
  - Division truncates toward zero.
  - Result is always between s[a] and s[a+1], so no saturation is needed.
  - Any exact method is allowed.
- Interp at a = i_end_addr: use s[a+1] := s[a], so the output holds.
- End of recording: if the next a > i_end_addr (compare at ADDR_W+1 bits, no wrap), then after outputting the current frame's sample:
  - on the next tick, go to IDLE;
  - pulse o_done once;
  - set o_dac_en := 0 and o_dac_data := 0.
- A mode or speed change while running takes effect at the next tick, with k := 0.
- i_end_addr = 0: exactly one sample is played.
- PAUSED: o_dac_en = 0, o_dac_data = 0, address and k held.
- Reset values: o_sram_addr 0, o_sram_rd 0, o_dac_data 0, o_dac_en 0, o_state IDLE, o_done 0. Internal k, address, and the sample registers are also 0.
- Reset mid-FETCH abandons the fetch with no partial output.

## Timing
- Tick is detected 1 cycle after the i_daclrck rising edge. FETCH starts the next cycle (T0).
- T0: o_sram_addr = a, o_sram_rd = 1.
- T1: s[a] captured. Interp only: o_sram_addr = a+1, o_sram_rd = 1.
- T2: s[a+1] captured (interp).
- o_dac_data and o_dac_en are registered by T3, i.e. ≤5 cycles after the rising edge.
- o_dac_data is stable from then until the next tick. This requires ≥8 BCLK per LRCK half; the codec provides 32.
- o_sram_rd is high only in FETCH cycles.
- o_dac_en first rises in the first FETCH after play, never before valid data.

## Structure
- aud_pkg holds:
  - state enum (IDLE/RUN/FETCH/PAUSED);
  - speed-mode enum (NORMAL/FAST/SLOW_HOLD/SLOW_INTERP) derived from the three mode inputs;
  - ADDR_W/DATA_W defaults.
- Sub-module aud_interp: combinational (s0, s1, k, F) -> interpolated sample. It is reused by a future record-monitor path.

## Test plan
- Normal, i_end_addr=3, SRAM = 100,200,300,400, play → o_dac_data 100,200,300,400 on successive frames, then o_done pulse, state IDLE, o_dac_en 0.
- Fast, i_speed=1 (F=2), samples 0..9 = 0,10,…,90, i_end_addr=9 → outputs 0,20,40,60,80, then done.
- Slow hold, F=4, s0=1000, s1=2000 → 1000 for 4 frames, then 2000.
- Slow interp, F=4, s0=0, s1=-100 → 0, -25, -50, -75, then -100; and s0=0, s1=7, F=4 → 0, 1, 3, 5 (truncation toward zero).
- Pause after 2 frames, hold 3 frames, play → o_dac_en 0 and data 0 while paused; resume at sample 2 with no skip. Simultaneous pause+stop → IDLE.
- Async reset asserted during FETCH T1 → all outputs 0 and state IDLE immediately; a subsequent play starts at address 0.
